// File: rtl/braun_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst (async, active-high); in_valid/in_ready with dividend
// (2*WIDTH bits) and divisor (WIDTH bits); out_valid/out_ready with
// quotient (2*WIDTH bits), remainder (WIDTH bits) and div_by_zero.
module braun_divider #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero
);

    localparam int QW = 2 * WIDTH;
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [WIDTH:0]   r;
    logic [QW-1:0]    q;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   t;
    logic [WIDTH:0]   r_step;
    logic [QW-1:0]    q_step;
    logic             ge;
    logic             last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract when it fits. The extra top bit of t keeps
    // a shifted-out 1 from being lost before the compare.
    always_comb begin
        t      = {r[WIDTH-1:0], q[QW-1]};
        ge     = (t >= {1'b0, dvs});
        r_step = ge ? (t - {1'b0, dvs}) : t;
        q_step = {q[QW-2:0], ge};
        last   = (cnt == CW'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r           <= '0;
            q           <= '0;
            dvs         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvs <= divisor;
                        q   <= dividend;
                        r   <= '0;
                        cnt <= CW'(QW);
                        // Divide-by-zero skips the iterations entirely.
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend[WIDTH-1:0];
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r   <= r_step;
                    q   <= q_step;
                    cnt <= cnt - CW'(1);
                    if (last) begin
                        quotient    <= q_step;
                        remainder   <= r_step[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_braun_divider.sv
// Self-checking bench for braun_divider (WIDTH=4) against an
// arithmetic reference model using / and %.
module tb_braun_divider;

    localparam int WIDTH = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 div_by_zero;

    int errors = 0;
    int checks = 0;

    braun_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division; divisor 0 gives all-ones
    // quotient and the low dividend bits as remainder.
    function automatic int ref_q(input int dd, input int ds);
        return (ds == 0) ? 255 : dd / ds;
    endfunction

    function automatic int ref_r(input int dd, input int ds);
        return (ds == 0) ? (dd % 16) : dd % ds;
    endfunction

    // 4x4 multiplier model used for the round-trip check.
    function automatic int mul4(input int a, input int b);
        return (a % 16) * (b % 16);
    endfunction

    // Presents one operation, waits for acceptance and for out_valid.
    // lat = edges after the accept edge until out_valid is seen.
    task automatic do_op(input int dd, input int ds, output int lat);
        int n;
        in_valid = 1'b1;
        dividend = 8'(dd);
        divisor  = 4'(ds);
        n = 0;
        while (!in_ready && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL done_timeout out_valid=%0b required 1", out_valid);
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 8'd0 ||
            remainder !== 4'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got rdy=%0b vld=%0b q=%0d r=%0d z=%0b required 1 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int dds[4] = '{200, 225, 255, 5};
        int dss[4] = '{7, 15, 1, 9};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_op(dds[i], dss[i], lat);
            checks++;
            if (lat !== 8) begin
                errors++;
                $display("FAIL basic_latency %0d/%0d got %0d required 8",
                         dds[i], dss[i], lat);
            end
            checks++;
            if (quotient !== 8'(ref_q(dds[i], dss[i])) ||
                remainder !== 4'(ref_r(dds[i], dss[i])) ||
                div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL basic_result %0d/%0d got q=%0d r=%0d z=%0b required q=%0d r=%0d z=0",
                         dds[i], dss[i], quotient, remainder, div_by_zero,
                         ref_q(dds[i], dss[i]), ref_r(dds[i], dss[i]));
            end
            finish_op();
        end
    endtask

    task automatic test_div_zero();
        int lat;
        out_ready = 1'b0;
        do_op(100, 0, lat);
        checks++;
        if (lat !== 0) begin
            errors++;
            $display("FAIL dbz_latency got %0d extra edges required 0", lat);
        end
        checks++;
        if (quotient !== 8'd255 || remainder !== 4'd4 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_result got q=%0d r=%0d z=%0b required q=255 r=4 z=1",
                     quotient, remainder, div_by_zero);
        end
        finish_op();
        do_op(100, 3, lat);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL after_dbz_latency got %0d required 8", lat);
        end
        checks++;
        if (quotient !== 8'd33 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL after_dbz_result got q=%0d r=%0d z=%0b required q=33 r=1 z=0",
                     quotient, remainder, div_by_zero);
        end
        finish_op();
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        do_op(200, 7, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            dividend = 8'($urandom);
            divisor  = 4'($urandom_range(1, 15));
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                quotient !== 8'd28 || remainder !== 4'd4 || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d got vld=%0b rdy=%0b q=%0d r=%0d required 1 0 28 4",
                         i, out_valid, in_ready, quotient, remainder);
            end
        end
        in_valid = 1'b0;
        finish_op();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            quotient !== 8'd28 || remainder !== 4'd4) begin
            errors++;
            $display("FAIL release got vld=%0b rdy=%0b q=%0d r=%0d required 0 1 28 4",
                     out_valid, in_ready, quotient, remainder);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        out_ready = 1'b0;
        in_valid = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 8'd0 ||
            remainder !== 4'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got rdy=%0b vld=%0b q=%0d r=%0d z=%0b required 1 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(50, 6, lat);
        checks++;
        if (lat !== 8 || quotient !== 8'd8 || remainder !== 4'd2 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_op got lat=%0d q=%0d r=%0d z=%0b required 8 8 2 0",
                     lat, quotient, remainder, div_by_zero);
        end
        finish_op();
    endtask

    task automatic test_back_to_back();
        int stride, off, idx, dd, ds, lat, eq, er;
        stride = $urandom_range(0, 2047) * 2 + 1;
        off    = $urandom_range(0, 4095);
        for (int k = 0; k < 4096; k++) begin
            idx = (k * stride + off) % 4096;
            dd = idx / 16;
            ds = idx % 16;
            eq = ref_q(dd, ds);
            er = ref_r(dd, ds);
            out_ready = 1'b0;
            do_op(dd, ds, lat);
            checks++;
            if (quotient !== 8'(eq) || remainder !== 4'(er) ||
                div_by_zero !== (ds == 0) || lat !== ((ds == 0) ? 0 : 8)) begin
                errors++;
                $display("FAIL sweep %0d/%0d got q=%0d r=%0d z=%0b lat=%0d required q=%0d r=%0d z=%0b lat=%0d",
                         dd, ds, quotient, remainder, div_by_zero, lat,
                         eq, er, (ds == 0), (ds == 0) ? 0 : 8);
            end
            if (ds != 0 && int'(quotient) < 16) begin
                checks++;
                if (mul4(int'(quotient), ds) + int'(remainder) != dd) begin
                    errors++;
                    $display("FAIL roundtrip %0d/%0d got q*d+r=%0d required %0d",
                             dd, ds, mul4(int'(quotient), ds) + int'(remainder), dd);
                end
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            finish_op();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
